// File: rtl/ysyx_22040759_pkg.sv
// Shared constants and types for the GPR write-back path.
// Source indices double as bit positions in request/grant vectors.
package ysyx_22040759_pkg;

  localparam int REG_AW = 5;
  localparam int XLEN   = 32;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

  typedef enum logic {
    SRC_EXU = 1'b0,
    SRC_LSU = 1'b1
  } src_t;

endpackage

// File: rtl/ysyx_22040759_rr_arb2.sv
// Two-way round-robin arbiter: on a tie the source that did not win last time
// is granted. Purely combinational; the caller owns the 'last' register.
module ysyx_22040759_rr_arb2
  import ysyx_22040759_pkg::*;
(
  input  logic [1:0] valid,
  input  src_t       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (valid[SRC_EXU] && (!valid[SRC_LSU] || last == SRC_LSU)) begin
      grant[SRC_EXU] = 1'b1;
    end else if (valid[SRC_LSU]) begin
      grant[SRC_LSU] = 1'b1;
    end
  end

endmodule

// File: rtl/ysyx_22040759_gpr_wb_arb.sv
// Shares the single GPR write port between EXU and LSU and keeps a per-register
// count of issued-but-not-written-back results for RAW hazard stalls.
module ysyx_22040759_gpr_wb_arb
  import ysyx_22040759_pkg::*;
#(
  parameter int NSRC   = 2,
  parameter int PCNT_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exu_valid,
  output logic              exu_ready,
  input  logic [REG_AW-1:0] exu_rd,
  input  logic [XLEN-1:0]   exu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [REG_AW-1:0] lsu_rd,
  input  logic [XLEN-1:0]   lsu_data,
  input  logic              iss_valid,
  output logic              iss_ready,
  input  logic [REG_AW-1:0] iss_rd,
  input  logic [REG_AW-1:0] raddr1,
  input  logic [REG_AW-1:0] raddr2,
  output logic              busy1,
  output logic              busy2,
  output logic              gpr_wen,
  output logic [REG_AW-1:0] gpr_waddr,
  output logic [XLEN-1:0]   gpr_wdata
);

  localparam int NREG = 1 << REG_AW;

  logic [NSRC-1:0]   req_valid;
  logic [NSRC-1:0]   grant;
  wb_req_t           req [NSRC];
  wb_req_t           sel;
  src_t              last_reg;
  src_t              last_next;
  logic              wb_hs;
  logic              iss_hs;
  logic [PCNT_W-1:0] pcnt [NREG];
  logic [NREG-1:1]   inc_vec;
  logic [NREG-1:1]   dec_vec;

  assign req_valid[SRC_EXU] = exu_valid;
  assign req_valid[SRC_LSU] = lsu_valid;
  assign req[SRC_EXU]       = '{rd: exu_rd, data: exu_data};
  assign req[SRC_LSU]       = '{rd: lsu_rd, data: lsu_data};

  ysyx_22040759_rr_arb2 u_arb (
    .valid (req_valid),
    .last  (last_reg),
    .grant (grant)
  );

  // The write port never stalls, so a grant is itself the handshake.
  assign exu_ready = grant[SRC_EXU];
  assign lsu_ready = grant[SRC_LSU];
  assign wb_hs     = |grant;
  assign sel       = grant[SRC_LSU] ? req[SRC_LSU] : req[SRC_EXU];

  always_comb begin
    last_next = last_reg;
    if (wb_hs) begin
      last_next = grant[SRC_LSU] ? SRC_LSU : SRC_EXU;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gpr_wen   <= 1'b0;
      gpr_waddr <= '0;
      gpr_wdata <= '0;
      last_reg  <= SRC_LSU;
    end else begin
      gpr_wen  <= wb_hs && (sel.rd != '0);
      last_reg <= last_next;
      if (wb_hs) begin
        gpr_waddr <= sel.rd;
        gpr_wdata <= sel.data;
      end
    end
  end

  assign iss_ready = !((iss_rd != '0) && (pcnt[iss_rd] == '1));
  assign iss_hs    = iss_valid && iss_ready;

  // No bypass: busy reflects the count before this edge's write-back.
  assign busy1 = (raddr1 != '0) && (pcnt[raddr1] != '0);
  assign busy2 = (raddr2 != '0) && (pcnt[raddr2] != '0);

  for (genvar gi = 1; gi < NREG; gi++) begin : g_cnt
    assign inc_vec[gi] = iss_hs && (iss_rd == REG_AW'(gi));
    assign dec_vec[gi] = wb_hs && (sel.rd == REG_AW'(gi));

    a_no_underflow : assert property (@(posedge clk) disable iff (rst)
      !(dec_vec[gi] && !inc_vec[gi] && (pcnt[gi] == '0)));
  end

  always_ff @(posedge clk) begin
    pcnt[0] <= '0;
    for (int i = 1; i < NREG; i++) begin
      if (rst) begin
        pcnt[i] <= '0;
      end else if (inc_vec[i] && !dec_vec[i]) begin
        pcnt[i] <= pcnt[i] + PCNT_W'(1);
      end else if (dec_vec[i] && !inc_vec[i] && (pcnt[i] != '0)) begin
        pcnt[i] <= pcnt[i] - PCNT_W'(1);
      end
    end
  end

endmodule

// File: doc/ysyx_22040759_gpr_wb_arb.md
# ysyx_22040759_gpr_wb_arb

Write-back arbiter and register scoreboard for the 32×32 GPR with its single write port. It shares that port between two write-back requesters, EXU (ALU results) and LSU (load data), using valid/ready handshakes and round-robin arbitration. It also tracks outstanding writes per register so the decode/issue logic can stall on read-after-write hazards. The block sits between the execute/memory stages and the GPR write port.

## Interface
- `NSRC`, 2: number of write-back requesters (fixed at 2; index 0 = EXU, 1 = LSU).
- `PCNT_W`, 2: width of the per-register pending-write counter; saturation value is 2^PCNT_W−1.
- `clk` in 1: clock, all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `exu_valid` in 1, `exu_ready` out 1, `exu_rd` in 5, `exu_data` in 32: EXU write-back request.
- `lsu_valid` in 1, `lsu_ready` out 1, `lsu_rd` in 5, `lsu_data` in 32: LSU write-back request.
- `iss_valid` in 1, `iss_ready` out 1, `iss_rd` in 5: issue of an instruction that will write `iss_rd`.
- `raddr1`, `raddr2` in 5: source registers of the instruction being decoded.
- `busy1`, `busy2` out 1: the matching source has pending writes (combinational).
- `gpr_wen` out 1, `gpr_waddr` out 5, `gpr_wdata` out 32: registered drive of the GPR write port.

## Operation
- Arbitration: each cycle at most one request is granted. `X_ready` is asserted only on the granted source and is combinational from the valids and the `last` register. A handshake is `valid && ready`.
- One requester valid: it is granted. Both valid: the source not equal to `last` wins. `last` updates to the granted index on every handshake.
- The write port always completes in one cycle, so there is no back-pressure from the GPR. A grant is available every cycle.
- Accepted request: `gpr_wen`, `gpr_waddr` and `gpr_wdata` are loaded on the next edge.
  - `rd == 0`: accepted, but `gpr_wen` is loaded as 0 and no counter changes.
  - No handshake: `gpr_wen` is loaded as 0. Address and data hold their previous values.
- Scoreboard: `pcnt[1..31]` holds one `PCNT_W`-bit counter per register. `pcnt[0]` is constant 0.
  - Increment: issue handshake (`iss_valid && iss_ready`) with `iss_rd != 0` increments `pcnt[iss_rd]`.
  - Decrement: a write-back handshake with `rd != 0` decrements `pcnt[rd]` in the same edge that loads the write register.
  - Same register incremented and decremented on the same edge: the count is unchanged.
  - `iss_ready` = 0 when `iss_rd != 0` and `pcnt[iss_rd]` is saturated (3). Otherwise `iss_ready` = 1.
  - A write-back to a register whose count is 0 is a protocol error. The counter stays at 0 (no underflow wrap) and a simulation-only assertion fires.
- `busyN = (raddrN != 0) && (pcnt[raddrN] != 0)`. The counter value before the clock edge is used; there is no bypass.

## Timing
- Reset, applied on an edge with `rst` = 1:
  - all `pcnt` = 0;
  - `gpr_wen` = 0, `gpr_waddr` = 0, `gpr_wdata` = 0;
  - `last` = 1, so EXU wins the first tie.
  - After reset, `exu_ready`/`lsu_ready` follow their valids, `iss_ready` = 1, and `busy1`/`busy2` = 0.
- Reset mid-operation: in-flight handshakes are discarded and pending counts are cleared. A `gpr_wen` loaded on the previous edge still appears for exactly the cycle in which the reset edge occurs, then drops to 0.
- Latency:
  - Handshake at edge N → `gpr_wen` high during the cycle after edge N, so the GPR writes at edge N+1.
  - The busy bit clears in the same cycle that `gpr_wen` is high.
  - A dependent reader sees the new GPR value one cycle after that. The issue logic must therefore delay one extra cycle after busy clears, or bypass from `gpr_wdata`.
- Throughput: one write per cycle. With both sources continuously valid, grants alternate 0,1,0,1…
- A source must hold `valid`, `rd` and `data` stable until its handshake completes.

## Structure
- Shared package `ysyx_22040759_pkg`:
  - constants `REG_AW` = 5 and `XLEN` = 32;
  - `typedef struct {rd, data}` for wb_req_t;
  - source index enum `SRC_EXU` = 0, `SRC_LSU` = 1.
- Sub-module `ysyx_22040759_rr_arb2`: 2-way round-robin arbiter (valids, `last` in; grant one-hot out).
- The scoreboard counter array stays in the top module.

## Test plan
- After reset, EXU valid, rd=5, data=0x1234 → `exu_ready`=1. Next cycle: `gpr_wen`=1, `gpr_waddr`=5, `gpr_wdata`=0x1234.
- Both sources valid for 4 cycles (EXU rd=1, LSU rd=2) → grants EXU, LSU, EXU, LSU. `gpr_waddr` sequence is 1, 2, 1, 2.
- Issue rd=7 three times → `busy1`=1 with `raddr1`=7. Then `iss_ready`=0 for `iss_rd`=7 while `iss_ready`=1 for `iss_rd`=8. Three write-backs to rd=7 → busy clears after the third.
- Issue rd=9 and write back rd=9 on the same edge while its count is 1 → count stays 1 and `busy` stays 1. Issue `iss_rd`=0 → `iss_ready`=1, no counter changes.
- LSU writes rd=0 with data 0xFFFFFFFF → handshake accepted, `gpr_wen`=0 next cycle.
- Counts nonzero and `gpr_wen`=1 with `rst` asserted → after the reset edge all busy bits are 0 and `gpr_wen`=0.
